apb_slave_mem: RTL and testbench

APB4 completer (slave) with a byte-strobed word register bank, runtime-programmable wait states and error response. It sits on the slave side of `apb_interface`, driving `pready`/`prdata`/`pslverr` in response to a master. It is the synthesizable DUT that the UVM master agent drives, and the reference model the slave agent is checked against.

---
 rtl/apb_slave_pkg.sv | 35 +++
 rtl/apb_slave_mem_if.sv | 26 ++
 rtl/apb_slave_regbank.sv | 60 ++++++
 rtl/apb_slave_mem.sv | 176 +++++++++++++++++
 tb/tb_apb_slave_mem.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_slave_pkg.sv
// Shared types and helpers for the APB4 completer with register bank:
// FSM state encoding, error-counter width and address decode.
package apb_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } apb_slave_state_t;

  localparam int ERR_CNT_W = 8;

  // Byte-offset bits inside one data word.
  function automatic int calc_ofs(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Flags a misaligned or out-of-range byte address.
  function automatic logic addr_err(input logic [63:0] addr, input int addr_w,
                                    input int data_w, input int depth);
    int          ofs;
    logic [63:0] a;
    logic [63:0] ofs_mask;
    ofs = calc_ofs(data_w);
    if (addr_w >= 64) begin
      a = addr;
    end else begin
      a = addr & ((64'd1 << addr_w) - 64'd1);
    end
    ofs_mask = (64'd1 << ofs) - 64'd1;
    return ((a & ofs_mask) != 64'd0) || ((a >> ofs) >= 64'(depth));
  endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB4 bus bundle between a requester (master) and a completer (slave).
interface apb_slave_mem_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   paddr;
  logic                    pprot;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_slave_regbank.sv
// DEPTH x DATA_WIDTH word storage with a byte-strobed write port and a
// registered read port whose output can be cleared to zero.
module apb_slave_regbank #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   idx,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic [DATA_WIDTH/8-1:0]    wr_strb,
  input  logic                       rd_en,
  input  logic                       rd_clr,
  output logic [DATA_WIDTH-1:0]      rd_data
);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Next bank contents and next read register value.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) begin
          mem_d[idx][8*b +: 8] = wr_data[8*b +: 8];
        end else begin
          mem_d[idx][8*b +: 8] = mem_q[idx][8*b +: 8];
        end
      end
    end else begin
      mem_d = mem_q;
    end

    if (rd_clr) begin
      rdata_d = '0;
    end else if (rd_en) begin
      rdata_d = mem_q[idx];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Bank and read register; reset wipes every word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rd_data = rdata_q;

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer: byte-strobed register bank, runtime wait states,
// error response and a saturating errored-transfer counter.
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  apb_slave_mem_if.slave       bus,
  input  logic [3:0]           wait_cfg,
  output logic [ERR_CNT_W-1:0] err_count
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFS    = calc_ofs(DATA_WIDTH);
  localparam int IDX_W  = $clog2(DEPTH);

  apb_slave_state_t      state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic                  err_q, err_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;

  logic                  enter_done_s;
  logic                  leave_s;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic                  rd_clr_s;
  logic [DATA_WIDTH-1:0] rdata_s;
  logic                  unused_pprot_s;

  assign unused_pprot_s = bus.pprot;

  // Transfer FSM: next state, latched request, wait counter and responses.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    pready_d     = pready_q;
    pslverr_d    = pslverr_q;
    err_count_d  = err_count_q;
    enter_done_s = 1'b0;
    leave_s      = 1'b0;
    wr_en_s      = 1'b0;
    rd_en_s      = 1'b0;
    rd_clr_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.psel && !bus.penable) begin
          state_d = ST_SETUP;
          idx_d   = bus.paddr[OFS+IDX_W-1:OFS];
          write_d = bus.pwrite;
          wdata_d = bus.pwdata;
          strb_d  = bus.pstrb;
          err_d   = addr_err(64'(bus.paddr), ADDR_WIDTH, DATA_WIDTH, DEPTH);
          cnt_d   = wait_cfg;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (!bus.psel) begin
          leave_s = 1'b1;
        end else if (cnt_q == 4'd0) begin
          enter_done_s = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!bus.psel) begin
          leave_s = 1'b1;
        end else if (cnt_q == 4'd1) begin
          enter_done_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (!bus.psel) begin
          leave_s = 1'b1;
        end else if (bus.penable && pready_q) begin
          // Completing edge: commit good writes and count errored transfers.
          leave_s = 1'b1;
          wr_en_s = write_q && !err_q;
          if (pslverr_q && (err_count_q != {ERR_CNT_W{1'b1}})) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
          end else begin
            err_count_d = err_count_q;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        leave_s = 1'b1;
      end
    endcase

    // Good reads load the bank word on the same edge that raises pready.
    if (enter_done_s) begin
      state_d   = ST_DONE;
      pready_d  = 1'b1;
      pslverr_d = err_q;
      rd_en_s   = !write_q && !err_q;
      rd_clr_s  = write_q || err_q;
    end else if (leave_s) begin
      state_d   = ST_IDLE;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      rd_clr_s  = 1'b1;
    end else begin
      rd_clr_s  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      err_q       <= 1'b0;
      cnt_q       <= 4'd0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      err_count_q <= err_count_d;
    end
  end

  apb_slave_regbank #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_bank (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en_s),
    .idx    (idx_q),
    .wr_data(wdata_q),
    .wr_strb(strb_q),
    .rd_en  (rd_en_s),
    .rd_clr (rd_clr_s),
    .rd_data(rdata_s)
  );

  assign bus.prdata  = rdata_s;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench for apb_slave_mem: directed APB scenarios plus
// randomized transfers against a word-array reference model.
module tb_apb_slave_mem;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int SW    = DW / 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] wait_cfg;
  logic [7:0] err_count;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] model_mem [DEPTH];
  int            model_err;

  logic [DW-1:0] rd;
  logic          se;
  int            cyc;

  apb_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .wait_cfg (wait_cfg),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_addr_err(input logic [AW-1:0] a);
    return ((int'(a) % SW) != 0) || ((int'(a) / SW) >= DEPTH);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_err = 0;
  endtask

  task automatic bus_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
    end
  endtask

  // One complete APB transfer, checked against the model.
  task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                      input logic [SW-1:0] strb, input logic [3:0] wcfg,
                      output logic [DW-1:0] rdata, output logic slverr, output int cycles);
    bit            exp_err;
    logic [DW-1:0] exp_rd;
    int            idx;
    bit            done;
    @(negedge clk);
    check("pready_idle", 64'(bus.pready), 64'(1'b0));
    check("err_count", 64'(err_count), 64'(model_err));
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.paddr   = addr;
    bus.pwrite  = wr;
    bus.pwdata  = wdata;
    bus.pstrb   = strb;
    bus.pprot   = 1'($urandom);
    wait_cfg    = wcfg;
    exp_err = model_addr_err(addr);
    idx     = int'(addr) / SW;
    exp_rd  = '0;
    if (!wr && !exp_err) exp_rd = model_mem[idx];
    @(negedge clk);
    bus.penable = 1'b1;
    wait_cfg    = 4'($urandom);
    cycles = 1;
    done   = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (bus.pready === 1'b1) begin
        done = 1'b1;
      end else begin
        @(negedge clk);
        cycles++;
      end
    end
    check("timeout", 64'(done), 64'(1'b1));
    rdata  = bus.prdata;
    slverr = bus.pslverr;
    if (done) begin
      check("cycles", 64'(cycles), 64'(2 + int'(wcfg)));
      check("pslverr", 64'(slverr), 64'(exp_err));
      if (!wr) check("prdata", 64'(rdata), 64'(exp_rd));
      if (wr && !exp_err) begin
        for (int b = 0; b < SW; b++)
          if (strb[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end
      if (exp_err && model_err < 255) model_err++;
    end else begin
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    int            sel;
    reset       = 1'b1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.paddr   = '0;
    bus.pwrite  = 1'b0;
    bus.pwdata  = '0;
    bus.pstrb   = '0;
    bus.pprot   = 1'b0;
    wait_cfg    = 4'd0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_pready", 64'(bus.pready), 64'(1'b0));
    check("rst_pslverr", 64'(bus.pslverr), 64'(1'b0));
    check("rst_prdata", 64'(bus.prdata), 64'(0));
    check("rst_err_count", 64'(err_count), 64'(0));
    reset = 1'b0;

    // Zero-wait write then read.
    xfer(16'h0004, 1'b1, 32'hDEADBEEF, 4'hF, 4'd0, rd, se, cyc);
    check("wr_2cyc", 64'(cyc), 64'(2));
    xfer(16'h0004, 1'b0, 32'h0, 4'h0, 4'd0, rd, se, cyc);
    check("rd_deadbeef", 64'(rd), 64'(32'hDEADBEEF));

    // Partial strobe merge.
    xfer(16'h0008, 1'b1, 32'h11223344, 4'hF, 4'd0, rd, se, cyc);
    xfer(16'h0008, 1'b1, 32'hAABBCCDD, 4'h5, 4'd0, rd, se, cyc);
    xfer(16'h0008, 1'b0, 32'h0, 4'hF, 4'd0, rd, se, cyc);
    check("rd_partial", 64'(rd), 64'(32'h11BB33DD));

    // Three wait states on a read.
    xfer(16'h0008, 1'b0, 32'h0, 4'h0, 4'd3, rd, se, cyc);
    check("wait3_cycles", 64'(cyc), 64'(5));

    // Out-of-range write and misaligned read.
    xfer(16'h0040, 1'b1, 32'hFFFFFFFF, 4'hF, 4'd0, rd, se, cyc);
    check("oor_slverr", 64'(se), 64'(1'b1));
    bus_idle(1);
    check("err_cnt1", 64'(err_count), 64'(1));
    xfer(16'h0000, 1'b0, 32'h0, 4'h0, 4'd0, rd, se, cyc);
    check("oor_no_write", 64'(rd), 64'(0));
    xfer(16'h0002, 1'b0, 32'h0, 4'h0, 4'd1, rd, se, cyc);
    check("mis_slverr", 64'(se), 64'(1'b1));
    check("mis_prdata", 64'(rd), 64'(0));
    bus_idle(1);
    check("err_cnt2", 64'(err_count), 64'(2));

    // Drop psel during WAIT of a write.
    xfer(16'h000C, 1'b1, 32'h12345678, 4'hF, 4'd0, rd, se, cyc);
    @(negedge clk);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.paddr   = 16'h000C;
    bus.pwrite  = 1'b1;
    bus.pwdata  = 32'hFFFF0000;
    bus.pstrb   = 4'hF;
    wait_cfg    = 4'd3;
    @(negedge clk);
    bus.penable = 1'b1;
    repeat (2) @(negedge clk);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    @(negedge clk);
    check("abort_pready", 64'(bus.pready), 64'(1'b0));
    xfer(16'h000C, 1'b0, 32'h0, 4'h0, 4'd2, rd, se, cyc);
    check("abort_no_write", 64'(rd), 64'(32'h12345678));

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 75) a = AW'($urandom_range(0, DEPTH - 1) * SW);
      else if (sel < 88) a = AW'($urandom_range(0, DEPTH - 1) * SW + $urandom_range(1, SW - 1));
      else a = AW'($urandom_range(DEPTH * SW, 65535));
      xfer(a, 1'($urandom), DW'($urandom), SW'($urandom), 4'($urandom_range(0, 4)), rd, se, cyc);
      if ($urandom_range(0, 4) == 0) bus_idle(int'($urandom_range(1, 2)));
    end

    // Reset during DONE of a write to word 0.
    xfer(16'h0000, 1'b1, 32'h5555AAAA, 4'hF, 4'd0, rd, se, cyc);
    @(negedge clk);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.paddr   = 16'h0000;
    bus.pwrite  = 1'b1;
    bus.pwdata  = 32'hCAFEF00D;
    bus.pstrb   = 4'hF;
    wait_cfg    = 4'd0;
    @(negedge clk);
    bus.penable = 1'b1;
    @(negedge clk);
    check("done_pready", 64'(bus.pready), 64'(1'b1));
    reset = 1'b1;
    #1;
    check("rst_async_pready", 64'(bus.pready), 64'(1'b0));
    check("rst_async_errcnt", 64'(err_count), 64'(0));
    model_clear();
    @(negedge clk);
    reset       = 1'b0;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    xfer(16'h0000, 1'b0, 32'h0, 4'h0, 4'd0, rd, se, cyc);
    check("rst_no_commit", 64'(rd), 64'(0));
    xfer(16'h0004, 1'b0, 32'h0, 4'h0, 4'd0, rd, se, cyc);
    check("rst_bank_clear", 64'(rd), 64'(0));

    // Saturation of the error counter.
    for (int n = 0; n < 260; n++) begin
      if (n % 2 == 0) a = AW'($urandom_range(DEPTH * SW, 65535));
      else a = AW'($urandom_range(0, DEPTH - 1) * SW + $urandom_range(1, SW - 1));
      xfer(a, 1'(n % 3 == 0), DW'($urandom), 4'hF, 4'd0, rd, se, cyc);
    end
    bus_idle(1);
    check("err_sat", 64'(err_count), 64'(255));
    xfer(16'h0010, 1'b1, 32'h0BADF00D, 4'hF, 4'd1, rd, se, cyc);
    xfer(16'h0010, 1'b0, 32'h0, 4'h0, 4'd0, rd, se, cyc);
    check("post_sat_rd", 64'(rd), 64'(32'h0BADF00D));
    bus_idle(2);
    check("err_sat_hold", 64'(err_count), 64'(255));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
